// File: rtl/expr_pkg.sv
// Shared definitions for the expression evaluator and its character classifier.
//   - state_t : evaluator FSM state encoding (2 bits)
//   - CH_*    : ASCII codes of the characters the stream may carry
package expr_pkg;

    typedef enum logic [1:0] {
        S_OPND = 2'd0,   // expecting a digit
        S_OPR  = 2'd1,   // expecting an operator
        S_ERR  = 2'd2    // absorbing error state
    } state_t;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier for the expression stream.
// Ports:
//   in       : ASCII character
//   is_digit : in is '0'..'9'
//   is_plus  : in is '+'
//   is_mul   : in is '*'
//   digit    : numeric value of in when is_digit, else 0
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] in,
    output logic       is_digit,
    output logic       is_plus,
    output logic       is_mul,
    output logic [3:0] digit
);

    logic [7:0] offset_s;

    assign offset_s = in - CH_0;

    // Decode the character class and digit value
    always_comb begin
        is_digit = 1'b0;
        is_plus  = 1'b0;
        is_mul   = 1'b0;
        digit    = 4'd0;
        if ((in >= CH_0) && (in <= CH_9)) begin
            is_digit = 1'b1;
            digit    = offset_s[3:0];
        end else begin
            is_plus = (in == CH_PLUS);
            is_mul  = (in == CH_MUL);
        end
    end

endmodule

// File: rtl/expr_evaluator.sv
// Incremental evaluator for digit (op digit)* streams with '+' and '*',
// where '*' binds tighter than '+'. sum holds the closed additive part,
// term the product still being built.
// Ports:
//   clk      : clock, rising edge
//   clr      : synchronous active-low reset
//   in       : ASCII character
//   in_valid : in is consumed on this edge
//   valid    : consumed prefix is well-formed and ends in a digit
//   result   : value of the consumed prefix mod 2^W
//   err      : sticky illegal character / order
//   ovf      : sticky arithmetic overflow
module expr_evaluator
    import expr_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic         valid,
    output logic [W-1:0] result,
    output logic         err,
    output logic         ovf
);

    state_t       state_r, state_n_s;
    logic [W-1:0] sum_r, sum_n_s;
    logic [W-1:0] term_r, term_n_s;
    logic [W-1:0] result_r, result_n_s;
    logic         mul_pend_r, mul_pend_n_s;
    logic         valid_r, err_r, ovf_r, ovf_n_s;

    logic         is_digit_s, is_plus_s, is_mul_s;
    logic [3:0]   digit_s;
    logic [W+3:0] prod_s;
    logic [W:0]   acc_s;
    logic [W-1:0] term_dig_s;
    logic [W:0]   res_s;
    logic         mul_ovf_s;

    expr_char_class u_class (
        .in       (in),
        .is_digit (is_digit_s),
        .is_plus  (is_plus_s),
        .is_mul   (is_mul_s),
        .digit    (digit_s)
    );

    // Arithmetic is computed wide so the discarded bits reveal overflow
    assign prod_s     = {4'd0, term_r} * {{W{1'b0}}, digit_s};
    assign acc_s      = {1'b0, sum_r} + {1'b0, term_r};
    assign term_dig_s = mul_pend_r ? prod_s[W-1:0] : {{(W-4){1'b0}}, digit_s};
    assign res_s      = {1'b0, sum_r} + {1'b0, term_dig_s};
    assign mul_ovf_s  = mul_pend_r && (prod_s[W+3:W] != 4'd0);

    // Next-state and datapath updates; everything holds unless a char is consumed
    always_comb begin
        state_n_s    = state_r;
        sum_n_s      = sum_r;
        term_n_s     = term_r;
        result_n_s   = result_r;
        mul_pend_n_s = mul_pend_r;
        ovf_n_s      = ovf_r;
        if (in_valid) begin
            case (state_r)
                S_OPND: begin
                    if (is_digit_s) begin
                        state_n_s    = S_OPR;
                        term_n_s     = term_dig_s;
                        mul_pend_n_s = 1'b0;
                        result_n_s   = res_s[W-1:0];
                        ovf_n_s      = ovf_r | mul_ovf_s | res_s[W];
                    end else begin
                        state_n_s = S_ERR;
                    end
                end
                S_OPR: begin
                    if (is_plus_s) begin
                        state_n_s = S_OPND;
                        sum_n_s   = acc_s[W-1:0];
                        term_n_s  = {W{1'b0}};
                        ovf_n_s   = ovf_r | acc_s[W];
                    end else if (is_mul_s) begin
                        state_n_s    = S_OPND;
                        mul_pend_n_s = 1'b1;
                    end else begin
                        state_n_s = S_ERR;
                    end
                end
                S_ERR:   state_n_s = S_ERR;
                default: state_n_s = S_ERR;
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // State and output registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r    <= S_OPND;
            sum_r      <= {W{1'b0}};
            term_r     <= {W{1'b0}};
            result_r   <= {W{1'b0}};
            mul_pend_r <= 1'b0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            sum_r      <= sum_n_s;
            term_r     <= term_n_s;
            result_r   <= result_n_s;
            mul_pend_r <= mul_pend_n_s;
            valid_r    <= (state_n_s == S_OPR);
            err_r      <= (state_n_s == S_ERR);
            ovf_r      <= ovf_n_s;
        end
    end

    assign valid  = valid_r;
    assign result = result_r;
    assign err    = err_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_expr_evaluator.sv
// Directed bench for expr_evaluator: a W=16 instance for most scenarios and
// a W=8 instance sharing the same inputs for the overflow scenario.
module tb_expr_evaluator;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  in = 8'h00;
    logic        in_valid = 1'b0;
    logic        valid;
    logic [15:0] result;
    logic        err, ovf;
    logic        valid8;
    logic [7:0]  result8;
    logic        err8, ovf8;
    int          checks = 0;
    int          failures = 0;

    expr_evaluator #(.W(16)) dut (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .valid(valid), .result(result), .err(err), .ovf(ovf)
    );

    expr_evaluator #(.W(8)) dut8 (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .valid(valid8), .result(result8), .err(err8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input logic [7:0] c, input logic v);
        in       = c;
        in_valid = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        step(8'h39, 1'b1);
        clr = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({valid, result, err, ovf} !== 19'd0) begin
            $display("FAIL reset_outputs: got v=%0b r=%0d e=%0b o=%0b want all 0", valid, result, err, ovf);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  s [5]    = '{8'h31, 8'h2B, 8'h32, 8'h2A, 8'h33};
        logic        ev [5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] er [5]   = '{16'd1, 16'd1, 16'd3, 16'd3, 16'd7};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in = s[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (valid !== ev[i] || result !== er[i]) begin
                $display("FAIL b2b_char%0d: got v=%0b r=%0d want v=%0b r=%0d", i, valid, result, ev[i], er[i]);
                failures++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (err !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL b2b_flags: got e=%0b o=%0b want 0 0", err, ovf);
            failures++;
        end
    endtask

    task automatic test_bubbles();
        logic [7:0]  s [7]  = '{8'h32, 8'h2A, 8'h33, 8'h2A, 8'h34, 8'h2B, 8'h35};
        logic        ev [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] er [7] = '{16'd2, 16'd2, 16'd6, 16'd6, 16'd24, 16'd24, 16'd29};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(s[i], 1'b1);
            checks++;
            if (valid !== ev[i] || result !== er[i]) begin
                $display("FAIL bubble_char%0d: got v=%0b r=%0d want v=%0b r=%0d", i, valid, result, ev[i], er[i]);
                failures++;
            end
            // bubble carries a character that would be illegal if consumed
            step(8'h21, 1'b0);
            checks++;
            if (valid !== ev[i] || result !== er[i] || err !== 1'b0) begin
                $display("FAIL bubble_hold%0d: got v=%0b r=%0d e=%0b want v=%0b r=%0d e=0", i, valid, result, err, ev[i], er[i]);
                failures++;
            end
        end
    endtask

    task automatic test_double_op();
        do_reset();
        step(8'h31, 1'b1);
        step(8'h2B, 1'b1);
        step(8'h2B, 1'b1);
        checks++;
        if (err !== 1'b1 || valid !== 1'b0) begin
            $display("FAIL dblop_err: got e=%0b v=%0b want e=1 v=0", err, valid);
            failures++;
        end
        step(8'h32, 1'b1);
        checks++;
        if (err !== 1'b1 || valid !== 1'b0 || result !== 16'd1) begin
            $display("FAIL dblop_absorb: got e=%0b v=%0b r=%0d want e=1 v=0 r=1", err, valid, result);
            failures++;
        end
    endtask

    task automatic test_overflow_w8();
        do_reset();
        step(8'h39, 1'b1);
        step(8'h2A, 1'b1);
        step(8'h39, 1'b1);
        checks++;
        if (result8 !== 8'd81 || ovf8 !== 1'b0) begin
            $display("FAIL ovf8_81: got r=%0d o=%0b want r=81 o=0", result8, ovf8);
            failures++;
        end
        step(8'h2A, 1'b1);
        step(8'h39, 1'b1);
        checks++;
        if (result8 !== 8'd217 || ovf8 !== 1'b1 || valid8 !== 1'b1) begin
            $display("FAIL ovf8_729: got r=%0d o=%0b v=%0b want r=217 o=1 v=1", result8, ovf8, valid8);
            failures++;
        end
        checks++;
        if (result !== 16'd729 || ovf !== 1'b0) begin
            $display("FAIL ovf16_729: got r=%0d o=%0b want r=729 o=0", result, ovf);
            failures++;
        end
        step(8'h2B, 1'b1);
        step(8'h31, 1'b1);
        checks++;
        if (result8 !== 8'd218 || ovf8 !== 1'b1 || valid8 !== 1'b1) begin
            $display("FAIL ovf8_plus1: got r=%0d o=%0b v=%0b want r=218 o=1 v=1", result8, ovf8, valid8);
            failures++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(8'h34, 1'b1);
        step(8'h2A, 1'b1);
        step(8'h35, 1'b1);
        step(8'h2B, 1'b1);
        checks++;
        if (valid !== 1'b0 || result !== 16'd20) begin
            $display("FAIL trail_op: got v=%0b r=%0d want v=0 r=20", valid, result);
            failures++;
        end
        do_reset();
        checks++;
        if ({valid, result, err, ovf} !== 19'd0) begin
            $display("FAIL mid_reset: got v=%0b r=%0d e=%0b o=%0b want all 0", valid, result, err, ovf);
            failures++;
        end
        step(8'h38, 1'b1);
        checks++;
        if (valid !== 1'b1 || result !== 16'd8) begin
            $display("FAIL after_reset_8: got v=%0b r=%0d want v=1 r=8", valid, result);
            failures++;
        end
    endtask

    task automatic test_leading_op();
        do_reset();
        step(8'h2A, 1'b1);
        checks++;
        if (err !== 1'b1 || valid !== 1'b0) begin
            $display("FAIL lead_op: got e=%0b v=%0b want e=1 v=0", err, valid);
            failures++;
        end
        step(8'h33, 1'b1);
        checks++;
        if (err !== 1'b1 || valid !== 1'b0) begin
            $display("FAIL lead_digit: got e=%0b v=%0b want e=1 v=0", err, valid);
            failures++;
        end
        do_reset();
        checks++;
        if (err !== 1'b0 || valid !== 1'b0) begin
            $display("FAIL lead_clear: got e=%0b v=%0b want e=0 v=0", err, valid);
            failures++;
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_double_op();
        test_overflow_w8();
        test_mid_reset();
        test_leading_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
